// File: rtl/mult_dispatcher.sv
// Operand dispatcher: buffers operand pairs, issues one multiply at a time over req/ack, registers the product.
// Push-to-req 2 cycles, ack-to-out 1 cycle; in_ready = FIFO not full, no issue while out_valid is held.

module mult_dispatcher_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign wr_rdy = (count != CNT_FULL);
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end
endmodule

module mult_dispatcher #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_product,
  output logic                    mul_req,
  output logic [2*DATA_WIDTH-1:0] mul_data_req,
  input  logic                    mul_ack,
  input  logic [2*DATA_WIDTH-1:0] mul_data_ack,
  output logic                    busy,
  output logic                    timeout_err
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } operands_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t    state;
  state_t    state_nxt;
  operands_t in_dat;
  operands_t head_dat;
  logic      head_vld;
  logic      pop;
  logic      clr_timer;
  logic      inc_timer;
  logic      capture;
  logic      drop;
  logic [TW-1:0] timer;

  assign in_dat.a = in_a;
  assign in_dat.b = in_b;

  mult_dispatcher_fifo #(
    .WIDTH ($bits(operands_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (in_dat),
    .rd_vld (head_vld),
    .rd_rdy (pop),
    .rd_dat (head_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Holding off while out_valid is high keeps exactly one product in flight or parked.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clr_timer = 1'b0;
    inc_timer = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (head_vld && !out_valid) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        clr_timer = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mul_ack) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TIMER_LAST) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end else begin
          inc_timer = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mul_req     = (state == ISSUE);
  assign timeout_err = drop;
  assign busy        = (state != IDLE) || head_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_data_req <= '0;
      timer        <= '0;
      out_valid    <= 1'b0;
      out_product  <= '0;
    end else begin
      if (pop) mul_data_req <= head_dat;
      if (clr_timer)      timer <= '0;
      else if (inc_timer) timer <= timer + TIMER_ONE;
      if (capture) begin
        out_product <= mul_data_ack;
        out_valid   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mult_dispatcher.sv
// Randomized bench for mult_dispatcher with a behavioural multiplier stub and an in-order operand scoreboard.

module tb_mult_dispatcher;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [2*DW-1:0] out_product;
  logic mul_req;
  logic [2*DW-1:0] mul_data_req;
  logic mul_ack = 1'b0;
  logic [2*DW-1:0] mul_data_ack = '0;
  logic busy;
  logic timeout_err;

  always #5 clk = ~clk;

  mult_dispatcher #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .mul_req(mul_req), .mul_data_req(mul_data_req),
    .mul_ack(mul_ack), .mul_data_ack(mul_data_ack), .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] out_log[$];

  bit stub_never = 0, stub_rand = 0, spur_idle = 0, spur_issue = 0, pending = 0;
  int stub_lat = 5, stub_cnt = 0;
  logic [15:0] stub_cap = '0, stub_prod = '0;
  int req_cyc = -1, ack_cyc = -1, out_cyc = -1, to_cyc = -1, push_cyc = -1;
  int n_req = 0, n_out = 0, n_to = 0, n_push = 0;
  logic prev_ov = 1'b0, prev_hs = 1'b0;
  logic [15:0] prev_prod = '0;

  function automatic logic [15:0] mul_ref(input logic [15:0] pair);
    return 16'(pair[15:8]) * 16'(pair[7:0]);
  endfunction

  function int cnt_sel(input int which);
    case (which)
      0: return n_req;
      1: return n_out;
      default: return n_to;
    endcase
  endfunction

  // One clock: multiplier stub at the falling edge, then scoreboard sampling, then past the rising edge.
  task automatic tick();
    @(negedge clk);
    mul_ack = 1'b0;
    mul_data_ack = 16'($urandom);
    if (rst) pending = 0;
    else if (pending && !stub_never) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        mul_ack = 1'b1; mul_data_ack = stub_prod; pending = 0; ack_cyc = cyc;
      end
    end else if (spur_idle) begin
      mul_ack = 1'b1; spur_idle = 0;
    end
    if (!rst && mul_req) begin
      checks++;
      if (pending || out_valid || exp_q.size() == 0 || mul_data_req !== exp_q[0]) begin
        errors++;
        $display("FAIL issue: req data %h out_valid %b pending %0d, required next queued pair %h with nothing in flight",
                 mul_data_req, out_valid, pending, (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx);
      end
      pending = 1; stub_cap = mul_data_req; stub_prod = mul_ref(mul_data_req);
      stub_cnt = stub_rand ? int'($urandom_range(1, 4*DW+3)) : stub_lat;
      req_cyc = cyc; n_req++;
      if (spur_issue) begin mul_ack = 1'b1; spur_issue = 0; end
    end
    #1;
    if (rst) begin
      exp_q.delete(); prev_ov = 1'b0; prev_hs = 1'b0;
    end else begin
      if (pending && cyc != req_cyc) begin
        checks++;
        if (mul_data_req !== stub_cap) begin
          errors++; $display("FAIL req_hold: mul_data_req %h, required %h", mul_data_req, stub_cap);
        end
      end
      if (prev_ov && !prev_hs) begin
        checks++;
        if (out_valid !== 1'b1 || out_product !== prev_prod) begin
          errors++; $display("FAIL out_hold: valid %b product %h, required 1 %h", out_valid, out_product, prev_prod);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL out_extra: product %h with no operation outstanding", out_product);
        end else begin
          if (out_product !== mul_ref(exp_q[0])) begin
            errors++; $display("FAIL product: got %h, required %h", out_product, mul_ref(exp_q[0]));
          end
          void'(exp_q.pop_front());
        end
        out_log.push_back(out_product); out_cyc = cyc; n_out++;
      end
      if (timeout_err) begin
        to_cyc = cyc; n_to++; pending = 0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_a, in_b}); push_cyc = cyc; n_push++;
      end
      prev_ov = out_valid; prev_hs = out_valid && out_ready; prev_prod = out_product;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    int c;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (k < 200) begin
      c = cyc; tick();
      if (push_cyc == c) break;
      k++;
    end
    if (k == 200) begin
      checks++; errors++; $display("FAIL push: pair %h %h not accepted within 200 cycles", a, b);
    end
  endtask

  task automatic wait_cnt(input int which, input int base, input string what);
    int k = 0;
    while (cnt_sel(which) <= base && k < 400) begin tick(); k++; end
    if (cnt_sel(which) <= base) begin
      checks++; errors++; $display("FAIL %s: event not seen within 400 cycles", what);
    end
  endtask

  task automatic drain();
    int k = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy || out_valid) && k < 3000) begin tick(); k++; end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain: %0d ops outstanding busy %b out_valid %b, required idle", exp_q.size(), busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks += 7;
    if (in_ready !== 1'b1)    begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    if (out_product !== 16'h0) begin errors++; $display("FAIL rst_out_product: got %h required 0", out_product); end
    if (mul_req !== 1'b0)     begin errors++; $display("FAIL rst_mul_req: got %b required 0", mul_req); end
    if (mul_data_req !== 16'h0) begin errors++; $display("FAIL rst_mul_data_req: got %h required 0", mul_data_req); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b required 0", timeout_err); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int r0, o0, p;
    stub_rand = 0; stub_lat = 6; out_ready = 1'b1; out_log.delete();
    r0 = n_req; o0 = n_out;
    push_pair(8'd13, 8'd11); p = push_cyc; in_valid = 1'b0;
    wait_cnt(0, r0, "single_req");
    checks += 3;
    if (req_cyc != p + 2) begin errors++; $display("FAIL single_req_time: req at %0d, required %0d", req_cyc, p + 2); end
    if (stub_cap !== 16'h0D0B) begin errors++; $display("FAIL single_req_data: got %h required 0d0b", stub_cap); end
    if (mul_req !== 1'b0) begin errors++; $display("FAIL single_req_len: mul_req %b one cycle after issue, required 0", mul_req); end
    wait_cnt(1, o0, "single_out");
    checks += 3;
    if (ack_cyc != req_cyc + 6) begin errors++; $display("FAIL single_ack_time: ack at %0d, required %0d", ack_cyc, req_cyc + 6); end
    if (out_cyc != ack_cyc + 1) begin errors++; $display("FAIL single_out_time: out at %0d, required %0d", out_cyc, ack_cyc + 1); end
    if (out_log.size() != 1 || out_log[0] !== 16'h008F) begin
      errors++; $display("FAIL single_product: got %0d results first %h, required 008f", out_log.size(), (out_log.size() != 0) ? out_log[0] : 16'hxxxx);
    end
    drain();
  endtask

  task automatic test_full_fifo();
    logic [7:0] a_t[5] = '{8'd255, 8'd0, 8'd1, 8'd128, 8'd7};
    logic [7:0] b_t[5] = '{8'd255, 8'd200, 8'd1, 8'd2, 8'd9};
    logic [15:0] p_t[5] = '{16'hFE01, 16'h0000, 16'h0001, 16'h0100, 16'h003F};
    stub_rand = 1; out_ready = 1'b1; out_log.delete();
    for (int i = 0; i < 5; i++) push_pair(a_t[i], b_t[i]);
    in_valid = 1'b0;
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b after 5 pushes, required 0", in_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b required 1", busy); end
    drain();
    checks++;
    if (out_log.size() != 5) begin errors++; $display("FAIL full_count: got %0d results required 5", out_log.size()); end
    for (int i = 0; i < 5 && i < out_log.size(); i++) begin
      checks++;
      if (out_log[i] !== p_t[i]) begin errors++; $display("FAIL full_order[%0d]: got %h required %h", i, out_log[i], p_t[i]); end
    end
  endtask

  task automatic test_backpressure();
    int r0, r1, k, hs;
    stub_rand = 0; stub_lat = 4; out_ready = 1'b0; out_log.delete(); r0 = n_req;
    push_pair(8'd3, 8'd5); push_pair(8'd6, 8'd7); in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 300) begin tick(); k++; end
    checks++;
    if (out_valid !== 1'b1 || out_product !== 16'd15) begin
      errors++; $display("FAIL bp_first: valid %b product %h, required 1 000f", out_valid, out_product);
    end
    for (int i = 0; i < 20; i++) tick();
    checks += 2;
    if (n_req != r0 + 1) begin errors++; $display("FAIL bp_no_issue: %0d requests, required %0d", n_req - r0, 1); end
    if (out_product !== 16'd15) begin errors++; $display("FAIL bp_hold: got %h required 000f", out_product); end
    out_ready = 1'b1;
    tick(); hs = out_cyc; r1 = n_req;
    wait_cnt(0, r1, "bp_second_req");
    checks++;
    if (req_cyc != hs + 2) begin errors++; $display("FAIL bp_req_time: req at %0d, required %0d", req_cyc, hs + 2); end
    drain();
    checks++;
    if (out_log.size() != 2 || out_log[1] !== 16'd42) begin
      errors++; $display("FAIL bp_second: %0d results last %h, required 2 results ending 002a", out_log.size(), (out_log.size() != 0) ? out_log[out_log.size()-1] : 16'hxxxx);
    end
  endtask

  task automatic test_timeout();
    int r0, r1, t0, first;
    stub_never = 1; stub_rand = 0; stub_lat = 5; out_ready = 1'b1; out_log.delete();
    r0 = n_req; t0 = n_to;
    push_pair(8'd9, 8'd9); push_pair(8'd4, 8'd5); in_valid = 1'b0;
    wait_cnt(0, r0, "to_req");
    first = req_cyc;
    wait_cnt(2, t0, "to_pulse");
    checks += 3;
    if (to_cyc != first + TO) begin errors++; $display("FAIL to_time: pulse at %0d, required %0d", to_cyc, first + TO); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_width: timeout_err %b cycle after pulse, required 0", timeout_err); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL to_out_valid: got %b required 0", out_valid); end
    stub_never = 0; r1 = n_req;
    wait_cnt(0, r1, "to_next_req");
    checks += 2;
    if (req_cyc != to_cyc + 2) begin errors++; $display("FAIL to_next_time: req at %0d, required %0d", req_cyc, to_cyc + 2); end
    if (stub_cap !== 16'h0405) begin errors++; $display("FAIL to_next_data: got %h required 0405", stub_cap); end
    drain();
    checks++;
    if (out_log.size() != 1 || out_log[0] !== 16'd20) begin
      errors++; $display("FAIL to_result: %0d results first %h, required 1 result 0014", out_log.size(), (out_log.size() != 0) ? out_log[0] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_wait();
    int r0;
    stub_never = 1; out_ready = 1'b1; out_log.delete(); r0 = n_req;
    push_pair(8'd1, 8'd2); push_pair(8'd3, 8'd4); push_pair(8'd5, 8'd6); push_pair(8'd7, 8'd8);
    in_valid = 1'b0;
    wait_cnt(0, r0, "rw_req");
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1; tick();
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rw_in_ready: got %b required 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy: got %b required 0", busy); end
    if (mul_req !== 1'b0) begin errors++; $display("FAIL rw_mul_req: got %b required 0", mul_req); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_out_valid: got %b required 0", out_valid); end
    rst = 1'b0; stub_never = 0; stub_lat = 7;
    push_pair(8'd10, 8'd12);
    drain();
    checks++;
    if (out_log.size() != 1 || out_log[0] !== 16'd120) begin
      errors++; $display("FAIL rw_result: %0d results first %h, required 1 result 0078", out_log.size(), (out_log.size() != 0) ? out_log[0] : 16'hxxxx);
    end
  endtask

  task automatic test_spurious();
    int o0;
    out_ready = 1'b1; out_log.delete(); o0 = n_out;
    spur_idle = 1;
    for (int i = 0; i < 3; i++) tick();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL spur_idle_valid: got %b required 0", out_valid); end
    if (n_out != o0) begin errors++; $display("FAIL spur_idle_count: %0d outputs, required 0", n_out - o0); end
    spur_issue = 1; stub_rand = 0; stub_lat = 3;
    push_pair(8'd200, 8'd3);
    drain();
    checks++;
    if (out_log.size() != 1 || out_log[0] !== 16'h0258) begin
      errors++; $display("FAIL spur_result: %0d results first %h, required 1 result 0258", out_log.size(), (out_log.size() != 0) ? out_log[0] : 16'hxxxx);
    end
  endtask

  task automatic test_random();
    int o0, p0;
    stub_rand = 1; o0 = n_out; p0 = n_push;
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_a = 8'($urandom); in_b = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain();
    checks++;
    if (n_out - o0 != n_push - p0) begin
      errors++; $display("FAIL random_count: %0d results for %0d pushes", n_out - o0, n_push - p0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_fifo();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
